// File: rtl/y_mc_ctrl_if.sv
// Controller <-> datapath signal bundle for the multi-cycle control unit.
interface y_mc_ctrl_if;
  logic        go;
  logic [6:0]  opcode;
  logic        zero;
  logic        IRwrite;
  logic        RegWrite;
  logic        ALUSrc;
  logic        Mem2Reg;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  op;
  logic        PCwrite;
  logic [1:0]  PCsel;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] icount;

  // Controller side
  modport master (
    input  go, opcode, zero,
    output IRwrite, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite,
           op, PCwrite, PCsel, busy, halted, illegal, icount
  );

  // Datapath / stimulus side
  modport slave (
    output go, opcode, zero,
    input  IRwrite, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite,
           op, PCwrite, PCsel, busy, halted, illegal, icount
  );
endinterface

// File: rtl/y_mc_ctrl.sv
// Multi-cycle processor control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per
// opcode, counts retired instructions and halts after MAX_INSNS or on an
// illegal opcode.
module y_mc_ctrl #(
  parameter int unsigned MAX_INSNS = 43
) (
  input  logic     clk,
  input  logic     rst_n,
  y_mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_e;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  function automatic logic is_legal(input logic [6:0] o);
    return (o == OP_R) || (o == OP_I) || (o == OP_LD) ||
           (o == OP_ST) || (o == OP_BR) || (o == OP_JAL);
  endfunction

  // True when state s is the final (PC-updating) state for opcode o.
  function automatic logic is_last(input state_e s, input logic [6:0] o);
    return ((s == EXEC) && (o == OP_BR)) ||
           ((s == MEM)  && (o == OP_ST)) ||
           (s == WB);
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  opc_q, opc_d;
  logic [15:0] icount_q, icount_d;
  logic        illegal_q, illegal_d;
  logic        irwrite_q, irwrite_d;
  logic        regwrite_q, regwrite_d;
  logic        alusrc_q, alusrc_d;
  logic        mem2reg_q, mem2reg_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic [2:0]  aluop_q, aluop_d;
  logic        pcwrite_q, pcwrite_d;
  logic [1:0]  pcsel_q, pcsel_d;
  logic        brsel_q, brsel_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic [15:0] icount_inc;
  logic        in_ex;

  // Next state, opcode latch, retire counter; outputs are decoded from the
  // next state so they are registered yet aligned with the state they belong to.
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    icount_d   = icount_q;
    illegal_d  = illegal_q;
    icount_inc = icount_q + 16'd1;

    case (state_q)
      IDLE:   if (bus.go) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        opc_d = bus.opcode;
        if (is_legal(bus.opcode)) begin
          state_d = EXEC;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (opc_q == OP_LD || opc_q == OP_ST) state_d = MEM;
        else if (opc_q != OP_BR)              state_d = WB;
      end
      MEM:    if (opc_q == OP_LD) state_d = WB;
      WB:     state_d = WB;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && state_q != HALT && state_q != FETCH &&
        state_q != DECODE && is_last(state_q, opc_q)) begin
      icount_d = icount_inc;
      state_d  = (32'(icount_inc) < MAX_INSNS) ? FETCH : HALT;
    end

    in_ex      = (state_d == EXEC) || (state_d == MEM) || (state_d == WB);
    irwrite_d  = (state_d == FETCH);
    busy_d     = (state_d != IDLE) && (state_d != HALT);
    halted_d   = (state_d == HALT);
    alusrc_d   = in_ex && (opc_d != OP_R) && (opc_d != OP_BR);
    aluop_d    = in_ex ? ((opc_d == OP_BR) ? 3'b110 : 3'b010) : 3'b000;
    mem2reg_d  = in_ex && (opc_d == OP_LD);
    memread_d  = (state_d == MEM) && (opc_d == OP_LD);
    memwrite_d = (state_d == MEM) && (opc_d == OP_ST);
    regwrite_d = (state_d == WB);
    pcwrite_d  = in_ex && is_last(state_d, opc_d);
    pcsel_d    = (pcwrite_d && opc_d == OP_JAL) ? 2'b10 : 2'b00;
    brsel_d    = pcwrite_d && (opc_d == OP_BR);
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opc_q      <= '0;
      icount_q   <= '0;
      illegal_q  <= 1'b0;
      irwrite_q  <= 1'b0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      mem2reg_q  <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      aluop_q    <= '0;
      pcwrite_q  <= 1'b0;
      pcsel_q    <= '0;
      brsel_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      icount_q   <= icount_d;
      illegal_q  <= illegal_d;
      irwrite_q  <= irwrite_d;
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      mem2reg_q  <= mem2reg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      aluop_q    <= aluop_d;
      pcwrite_q  <= pcwrite_d;
      pcsel_q    <= pcsel_d;
      brsel_q    <= brsel_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.IRwrite  = irwrite_q;
  assign bus.RegWrite = regwrite_q;
  assign bus.ALUSrc   = alusrc_q;
  assign bus.Mem2Reg  = mem2reg_q;
  assign bus.MemRead  = memread_q;
  assign bus.MemWrite = memwrite_q;
  assign bus.op       = aluop_q;
  assign bus.PCwrite  = pcwrite_q;
  // Branch target select follows the live zero flag during the branch EXEC cycle.
  assign bus.PCsel    = brsel_q ? {1'b0, bus.zero} : pcsel_q;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;
  assign bus.illegal  = illegal_q;
  assign bus.icount   = icount_q;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Scoreboard bench for y_mc_ctrl: the driver issues opcodes on each fetch and
// queues the expected retirement; a negedge monitor checks every PCwrite cycle.
module tb_y_mc_ctrl;

  localparam int unsigned LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y_mc_ctrl_if bus();

  y_mc_ctrl #(.MAX_INSNS(LIMIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [6:0]  opc;
    int          len;
    logic [1:0]  pcsel;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        asrc;
    logic [2:0]  aop;
    int          mreads;
    logic [15:0] icnt;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        e;
  int unsigned mcnt = 0;
  int          cyc = 0;
  int          mr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic legal(input logic [6:0] o);
    return o == 7'h33 || o == 7'h13 || o == 7'h03 ||
           o == 7'h23 || o == 7'h63 || o == 7'h6F;
  endfunction

  // Expected observation at the retiring cycle of one instruction.
  function automatic exp_t model(input logic [6:0] o, input logic z, input logic [15:0] n);
    exp_t r;
    r.opc = o; r.icnt = n; r.pcsel = 2'b00; r.rw = 1'b0; r.mw = 1'b0;
    r.m2r = 1'b0; r.asrc = 1'b1; r.aop = 3'b010; r.mreads = 0; r.len = 4;
    case (o)
      7'h33: begin r.len = 4; r.rw = 1'b1; r.asrc = 1'b0; end
      7'h13: begin r.len = 4; r.rw = 1'b1; end
      7'h03: begin r.len = 5; r.rw = 1'b1; r.m2r = 1'b1; r.mreads = 1; end
      7'h23: begin r.len = 4; r.mw = 1'b1; end
      7'h63: begin r.len = 3; r.asrc = 1'b0; r.aop = 3'b110; r.pcsel = {1'b0, z}; end
      7'h6F: begin r.len = 4; r.rw = 1'b1; r.pcsel = 2'b10; end
      default: r.len = 0;
    endcase
    return r;
  endfunction

  // Monitor: per-cycle invariants and scoreboard pop on each PCwrite.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.IRwrite) begin
        cyc = 1;
        mr_cnt = 0;
      end else if (bus.busy) begin
        cyc++;
      end
      if (bus.MemRead) begin
        mr_cnt++;
        chk("m2r_in_mem", bus.Mem2Reg, 1);
      end
      chk("rd_wr_excl", bus.MemRead & bus.MemWrite, 0);
      if (!bus.PCwrite) chk("pcsel_no_pcwrite", bus.PCsel, 0);
      else begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pcwrite actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("insn_len", cyc, e.len);
          chk("pcsel", bus.PCsel, e.pcsel);
          chk("regwrite", bus.RegWrite, e.rw);
          chk("memwrite", bus.MemWrite, e.mw);
          chk("mem2reg", bus.Mem2Reg, e.m2r);
          chk("alusrc", bus.ALUSrc, e.asrc);
          chk("aluop", bus.op, e.aop);
          chk("memread_cycles", mr_cnt, e.mreads);
          chk("icount_before", bus.icount, e.icnt);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.go = 1'b0;
    #1;
    chk("reset_outputs", {bus.IRwrite, bus.RegWrite, bus.ALUSrc, bus.Mem2Reg,
                          bus.MemRead, bus.MemWrite, bus.op, bus.PCwrite, bus.PCsel,
                          bus.busy, bus.halted, bus.illegal}, 0);
    chk("reset_icount", bus.icount, 0);
    sb.delete();
    mcnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for the fetch strobe, present opcode through DECODE, then scramble it.
  task automatic issue(input logic [6:0] o, input logic z, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.IRwrite) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout actual=0 required=1");
      return;
    end
    bus.opcode = o;
    bus.zero   = z;
    if (legal(o)) begin
      sb.push_back(model(o, z, mcnt[15:0]));
      mcnt++;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.opcode = 7'($urandom);
  endtask

  task automatic episode(input bit [7:0] prog[$]);
    logic ok;
    logic exp_ill;
    exp_ill = 1'b0;
    do_reset();
    @(negedge clk);
    bus.go = 1'b1;
    foreach (prog[k]) begin
      issue(prog[k][6:0], prog[k][7], ok);
      if (!ok) break;
      if (!legal(prog[k][6:0])) begin
        exp_ill = 1'b1;
        break;
      end
      if (mcnt >= LIMIT) break;
    end
    repeat (4) @(negedge clk);
    chk("halted", bus.halted, 1);
    chk("busy_in_halt", bus.busy, 0);
    chk("illegal_flag", bus.illegal, exp_ill);
    chk("icount_final", bus.icount, mcnt);
    chk("sb_drained", sb.size(), 0);
    repeat (4) begin
      @(negedge clk);
      chk("go_ignored_in_halt", {bus.IRwrite, bus.halted}, 2'b01);
    end
    bus.go = 1'b0;
  endtask

  function automatic bit [7:0] rand_insn();
    logic [6:0] o;
    logic [6:0] tbl [6];
    tbl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    if ($urandom_range(0, 7) == 0) begin
      do o = 7'($urandom); while (legal(o));
    end else begin
      o = tbl[$urandom_range(0, 5)];
    end
    return {1'($urandom), o};
  endfunction

  initial begin
    bit [7:0] q[$];
    logic ok;
    logic found;
    bus.go = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;

    q = '{8'h33, 8'h03, 8'hA3};          episode(q);
    q = '{8'hE3, 8'h63, 8'h6F};          episode(q);
    q = '{8'h6F, 8'h7F};                 episode(q);
    q = '{8'h13, 8'h93, 8'h13, 8'h33};   episode(q);
    for (int n = 0; n < 25; n++) begin
      q.delete();
      for (int j = 0; j < 3; j++) q.push_back(rand_insn());
      episode(q);
    end

    // Reset in the MEM cycle of a load.
    do_reset();
    @(negedge clk);
    bus.go = 1'b1;
    issue(7'h03, 1'b0, ok);
    bus.go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (bus.MemRead) found = 1'b1;
    end
    chk("memread_reached", found, 1);
    rst_n = 1'b0;
    #1;
    chk("memread_drop_on_reset", bus.MemRead, 0);
    chk("icount_on_reset", bus.icount, 0);
    chk("busy_on_reset", bus.busy, 0);
    sb.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_wait", {bus.busy, bus.IRwrite, bus.PCwrite}, 0);
    end
    bus.go = 1'b1;
    @(negedge clk);
    chk("restart_fetch", bus.IRwrite, 1);
    bus.go = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/y_mc_ctrl.md
Y_MC_CTRL -- requirements
Module: y_mc_ctrl

Interface
REQ-001 SHALL have parameter MAX_INSNS, default 43: number of retired instructions after which the block halts.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port go  input  1  start request, sampled in IDLE.
REQ-005 SHALL have port opcode  input  7  instruction bits [6:0] from the fetch stage.
REQ-006 SHALL have port zero  input  1  ALU zero flag from the execute stage.
REQ-007 SHALL have port IRwrite  output  1  instruction-register load strobe.
REQ-008 SHALL have ports RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite  output  1 each  datapath controls.
REQ-009 SHALL have port op  output  3  ALU operation (010 add, 110 subtract).
REQ-010 SHALL have port PCwrite  output  1  PC update strobe.
REQ-011 SHALL have port PCsel  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-012 SHALL have ports busy, halted, illegal  output  1 each  status flags.
REQ-013 SHALL have port icount  output  16  retired-instruction count.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 SHALL move IDLE->FETCH when go=1; otherwise it SHALL remain in IDLE.
REQ-016 SHALL move FETCH->DECODE unconditionally and SHALL assert IRwrite=1 only in FETCH.
REQ-017 SHALL latch opcode into an internal register on the DECODE clock edge; all later decoding SHALL use the latched value.
REQ-018 SHALL use these sequences: 0x33/0x13 F,D,E,WB; 0x03 F,D,E,M,WB; 0x23 F,D,E,M; 0x63 F,D,E; 0x6F F,D,E,WB.
REQ-019 SHALL go DECODE->HALT and set illegal=1 (sticky) when opcode is not in {0x33,0x13,0x03,0x23,0x63,0x6F}.
REQ-020 SHALL drive ALUSrc, op and Mem2Reg from the latched opcode from EXEC until the last state of the instruction.
  - ALUSrc=0 for 0x33 and 0x63; 1 for all others.
  - op=110 for 0x63; 010 for all others.
  - Mem2Reg=1 for 0x03 only.
REQ-021 SHALL assert MemRead=1 only in MEM for 0x03, and MemWrite=1 only in MEM for 0x23; they SHALL never be asserted together.
REQ-022 SHALL assert RegWrite=1 only in WB.
REQ-023 SHALL assert PCwrite=1 for exactly one cycle, in the last state of each instruction.
REQ-024 SHALL set PCsel in that cycle as follows; PCsel SHALL be 00 whenever PCwrite=0.
  - 0x63: PCsel = {1'b0, zero}, combinational from zero in EXEC.
  - 0x6F: PCsel = 10.
  - All other opcodes: PCsel = 00.
REQ-025 SHALL increment icount on each PCwrite cycle, wrapping 0xFFFF->0x0000.
REQ-026 SHALL go to FETCH after the PCwrite cycle if the incremented icount is less than MAX_INSNS, else to HALT.
REQ-027 SHALL hold busy=1 in every state except IDLE and HALT.
REQ-028 SHALL hold halted=1 in HALT; HALT SHALL be left only via reset.
REQ-029 SHALL ignore go outside IDLE.
REQ-030 SHALL ignore zero outside EXEC of 0x63.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force state=IDLE, icount=0, illegal=0, opcode latch=0, and all outputs to 0.
REQ-032 SHALL abort any in-progress instruction on reset with no further strobes; after release it SHALL wait in IDLE for go.

Verification
REQ-033 R-type: go=1, opcode=0x33 -> IRwrite in cycle 1; EXEC with ALUSrc=0, op=010; WB with RegWrite=1, PCwrite=1, PCsel=00; icount=1.
REQ-034 Load then store: 0x03 -> MemRead=1 and Mem2Reg=1 in MEM, RegWrite=1 in WB (5 cycles); then 0x23 -> MemWrite=1 with PCwrite in MEM (4 cycles); icount=2.
REQ-035 Branch: 0x63 with zero=1 -> EXEC has op=110, PCwrite=1, PCsel=01; repeat with zero=0 -> PCsel=00; each instruction takes 3 cycles.
REQ-036 Jump and illegal: 0x6F -> PCsel=10 and RegWrite=1 in WB; then opcode=0x7F -> HALT, illegal=1, halted=1, busy=0, no PCwrite.
REQ-037 Limit: MAX_INSNS=3 with three 0x13 instructions -> halted=1 after the third WB, icount=3; go=1 then has no effect.
REQ-038 Reset mid-instruction: rst_n=0 asserted in MEM of a 0x03 -> MemRead drops immediately, icount=0; after release the block stays in IDLE until go=1.
